uart_frame_receiver: RTL and testbench

UART_FRAME_RECEIVER -- requirements
Module: uart_frame_receiver

---
 rtl/uart_frame_receiver_pkg.sv | 24 ++
 rtl/uart_frame_receiver_sync_2ff.sv | 25 ++
 rtl/uart_frame_receiver.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_receiver_pkg.sv
// Shared UART frame constants, receiver state encoding
// and the even-parity helper.
package uart_frame_receiver_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } rx_state_t;

    function automatic logic even_parity(
        input logic [DATA_BITS-1:0] i_d
    );
        return ^i_d;
    endfunction

endpackage

// File: rtl/uart_frame_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit;
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // shift the async input through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_frame_receiver.sv
// UART receiver: start, 8 data bits MSB first, even
// parity, optional stop; sticky ready/error flags.
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int IN_FREQ    = 20,
    parameter int OUT_FREQ   = 1,
    parameter int STOP_CHECK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data,
    output logic       ready,
    input  logic       reset_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CPB = IN_FREQ / OUT_FREQ;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

    rx_state_t      r_state;
    rx_state_t      w_next;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_par;
    logic           r_stop_low;
    logic           r_armed;
    logic [7:0]     r_data;
    logic           r_ready;
    logic           r_perr;
    logic           r_ferr;
    logic           r_ovr;
    logic           w_rxs;
    logic           w_zero;
    logic           w_busy;
    logic           w_done;
    logic           w_accept;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (rx_i),
        .o_q   (w_rxs)
    );

    assign w_zero   = (r_cnt == '0);
    assign w_accept = w_done && (!r_ready || reset_ready);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic; a start needs an armed line
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs && r_armed) w_next = S_START;
            end
            S_START: begin
                if (w_zero) begin
                    w_next = (w_rxs == START_BIT) ? S_DATA
                                                  : S_IDLE;
                end
            end
            S_DATA: begin
                if (w_zero && r_bit == LAST) w_next = S_PARITY;
            end
            S_PARITY: begin
                if (w_zero) begin
                    w_next = (STOP_CHECK != 0) ? S_STOP : S_DONE;
                end
            end
            S_STOP: begin
                if (w_zero) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // state-derived outputs
    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
    end

    // bit timer: half bit to mid start, then full bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_zero) begin
            case (w_next)
                S_START:  r_cnt <= HALF;
                S_DATA,
                S_PARITY,
                S_STOP:   r_cnt <= FULL;
                default:  r_cnt <= '0;
            endcase
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // mid-bit sampling of data, parity and stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_stop_low <= 1'b0;
        end else begin
            case (r_state)
                S_START: r_bit <= '0;
                S_DATA: begin
                    if (w_zero) begin
                        r_shift <= {r_shift[6:0], w_rxs};
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (w_zero) begin
                        r_par      <= w_rxs;
                        r_stop_low <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_zero) r_stop_low <= (w_rxs != STOP_BIT);
                end
                default: ;
            endcase
        end
    end

    // after a low stop bit, wait for the line to go high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b1;
        end else if (w_done && r_stop_low) begin
            r_armed <= 1'b0;
        end else if (w_rxs) begin
            r_armed <= 1'b1;
        end
    end

    // result flags; a completing frame beats reset_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_accept) begin
            r_data  <= r_shift;
            r_ready <= 1'b1;
            r_perr  <= (r_par != even_parity(r_shift));
            r_ferr  <= r_stop_low;
            if (reset_ready) r_ovr <= 1'b0;
        end else if (w_done) begin
            r_ovr <= 1'b1;
        end else if (reset_ready) begin
            r_ready <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign data       = r_data;
    assign ready      = r_ready;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = w_busy;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver: directed
// cases plus random frames against a flag-level model.
module tb_uart_frame_receiver;

    localparam int IN_FREQ    = 20;
    localparam int OUT_FREQ   = 1;
    localparam int STOP_CHECK = 1;
    localparam int CPB        = IN_FREQ / OUT_FREQ;
    localparam int LAT = 2 + CPB / 2 + (9 + STOP_CHECK) * CPB + 1;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic       rx_i        = 1'b1;
    logic       reset_ready = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int rise_cyc  = -1;
    int rr_s      = 0;
    logic ready_q = 1'b0;

    logic [7:0] m_data;
    logic       m_ready;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;

    logic [7:0] rb;
    logic       rpar;
    logic       rstp;
    logic       rwas;
    int         n;

    uart_frame_receiver #(
        .IN_FREQ    (IN_FREQ),
        .OUT_FREQ   (OUT_FREQ),
        .STOP_CHECK (STOP_CHECK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .data        (data),
        .ready       (ready),
        .reset_ready (reset_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready && !ready_q) rise_cyc = cyc;
        ready_q = ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic m_clear();
        m_ready = 1'b0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic m_reset();
        m_data = 8'h00;
        m_clear();
    endtask

    task automatic m_frame(input logic [7:0] b,
                           input logic par,
                           input logic stp);
        if (m_ready) begin
            m_ovr = 1'b1;
        end else begin
            m_data  = b;
            m_perr  = (par != ^b);
            m_ferr  = (STOP_CHECK != 0) && !stp;
            m_ready = 1'b1;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data"},  {24'h0, data}, {24'h0, m_data});
        chk({tag, ".ready"}, {31'h0, ready}, {31'h0, m_ready});
        chk({tag, ".perr"},  {31'h0, parity_err}, {31'h0, m_perr});
        chk({tag, ".ferr"},  {31'h0, frame_err}, {31'h0, m_ferr});
        chk({tag, ".ovr"},   {31'h0, overrun}, {31'h0, m_ovr});
        chk({tag, ".busy"},  {31'h0, busy}, 32'h0);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rr();
        reset_ready = 1'b1;
        tick(1);
        reset_ready = 1'b0;
    endtask

    task automatic chk_lat(input string tag);
        chk(tag, rise_cyc - start_cyc, LAT);
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input logic par,
                              input logic stp,
                              input logic tail,
                              input int rst_at);
        logic [10:0] f;
        int k;
        f = {1'b0, b, par, stp};
        k = 0;
        start_cyc = cyc + 1;
        rise_cyc  = -1;
        for (int i = 10; i >= 0; i--) begin
            for (int c = 0; c < CPB; c++) begin
                if (rst_at > 0 && k == rst_at) begin
                    rx_i  = 1'b1;
                    reset = 1'b0;
                    tick(3);
                    chk("rst.ready", {31'h0, ready}, 32'h0);
                    chk("rst.busy", {31'h0, busy}, 32'h0);
                    reset = 1'b1;
                    return;
                end
                rx_i = f[i];
                tick(1);
                k++;
            end
        end
        rx_i = tail;
    endtask

    initial begin
        m_reset();
        tick(4);
        chk_all("reset");
        reset = 1'b1;
        tick(5);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
        m_frame(8'hA5, 1'b0, 1'b1);
        tick(3);
        chk_lat("a5.lat");
        chk_all("a5");
        pulse_rr();
        m_clear();
        chk_all("a5.clr");

        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0);
        m_frame(8'h01, 1'b0, 1'b1);
        tick(3);
        chk_all("perr");
        pulse_rr();
        m_clear();

        rx_i = 1'b0;
        tick(5);
        rx_i = 1'b1;
        chk("glitch.busy_hi", {31'h0, busy}, 32'h1);
        n = 0;
        while (busy && n < 8) begin
            tick(1);
            n++;
        end
        chk("glitch.busy_lo", {31'h0, busy}, 32'h0);
        tick(2);
        chk_all("glitch");

        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0);
        m_frame(8'h3C, 1'b0, 1'b1);
        tick(3);
        chk_all("3c");
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 0);
        m_frame(8'hF0, 1'b0, 1'b1);
        tick(3);
        chk_all("ovr");
        pulse_rr();
        m_clear();
        chk_all("ovr.clr");

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0);
        m_frame(8'h55, 1'b0, 1'b0);
        tick(3);
        chk_all("ferr");
        tick(60);
        chk_all("ferr.hold_low");
        pulse_rr();
        m_clear();
        rx_i = 1'b1;
        tick(5);
        send_frame(8'h12, 1'b0, 1'b1, 1'b1, 0);
        m_frame(8'h12, 1'b0, 1'b1);
        tick(3);
        chk_lat("after_ferr.lat");
        chk_all("after_ferr");

        rr_s = cyc + 1;
        fork
            send_frame(8'h9A, 1'b0, 1'b1, 1'b1, 0);
            begin
                for (int w = 0; w < 400 && cyc != rr_s + LAT - 1; w++)
                    @(negedge clk);
                reset_ready = 1'b1;
                @(negedge clk);
                reset_ready = 1'b0;
            end
        join
        m_clear();
        m_frame(8'h9A, 1'b0, 1'b1);
        tick(3);
        chk_all("rr_done");

        pulse_rr();
        m_clear();
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1,
                   4 * CPB + CPB / 2);
        m_reset();
        tick(1);
        chk_all("abort");
        chk("abort.no_ready", rise_cyc, -1);
        tick(5);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 0);
        m_frame(8'h81, 1'b0, 1'b1);
        tick(3);
        chk_lat("after_abort.lat");
        chk_all("after_abort");

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                pulse_rr();
                m_clear();
            end
            rb   = 8'($urandom);
            rpar = (^rb) ^ ($urandom_range(0, 7) == 0);
            rstp = ($urandom_range(0, 5) != 0);
            rwas = m_ready;
            tick($urandom_range(1, 20));
            send_frame(rb, rpar, rstp, 1'b1, 0);
            m_frame(rb, rpar, rstp);
            tick(3);
            chk_all("rnd");
            if (!rwas) chk_lat("rnd.lat");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
